time_set_controller: RTL and testbench

//  Consumes the one-shot pulses of the two debounced buttons (MODE, INC) and keeps the clock's time of day.

---
 rtl/clock_pkg.sv | 16 +
 rtl/bcd_mod_counter.sv | 43 ++++
 rtl/time_set_controller.sv | 146 ++++++++++++++
 tb/tb_time_set_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and limits for the time-of-day clock.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int DEFAULT_TICKS_PER_SEC = 31_500_000;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD-1 -> 00, with a combinational carry.
module bcd_mod_counter #(
  parameter int MOD    = 60,
  parameter int TENS_W = 3
) (
  input  logic              regular_clk,
  input  logic              reset_n,
  input  logic              inc_en,
  input  logic              clear,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        ones,
  output logic              carry_out
);

  localparam logic [TENS_W-1:0] TENS_MAX = TENS_W'((MOD - 1) / 10);
  localparam logic [3:0]        ONES_MAX = 4'((MOD - 1) % 10);

  logic at_max;

  assign at_max    = (tens == TENS_MAX) && (ones == ONES_MAX);
  assign carry_out = inc_en && at_max;

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clear) begin
      tens <= '0;
      ones <= '0;
    end else if (inc_en) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        tens <= tens + TENS_W'(1);
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-of-day keeper with 1 s prescaler, MODE/INC button handling and edit-field blink.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int BLINK_DIV     = TICKS_PER_SEC / 4
) (
  input  logic       regular_clk,
  input  logic       reset_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  mode_t            state, state_next;
  logic             mode_q, inc_q;
  logic             mode_ev, inc_ev, inc_act;
  logic             set_entry, exit_to_run;
  logic [PRE_W-1:0] presc;
  logic [BLK_W-1:0] blink_cnt;
  logic             wrap;
  logic             sec_carry, min_carry;
  logic             sec_inc, min_inc, hour_inc;

  // Button edge detection: a held level yields a single event.
  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= mode_pulse;
      inc_q  <= inc_pulse;
    end
  end

  assign mode_ev = mode_pulse & ~mode_q;
  assign inc_ev  = inc_pulse & ~inc_q;
  assign inc_act = inc_ev & ~mode_ev;

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) state <= MODE_RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_ev) begin
      case (state)
        MODE_RUN:      state_next = MODE_SET_HOUR;
        MODE_SET_HOUR: state_next = MODE_SET_MIN;
        MODE_SET_MIN:  state_next = MODE_RUN;
        default:       state_next = MODE_RUN;
      endcase
    end
  end

  assign set_entry   = (state_next != state) && (state_next != MODE_RUN);
  assign exit_to_run = (state == MODE_SET_MIN) && (state_next == MODE_RUN);

  // Prescaler only runs in RUN; leaving SET_MIN restarts a full second.
  assign wrap = (state == MODE_RUN) && (presc == PRE_MAX);

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (exit_to_run) begin
      presc <= '0;
    end else if (state == MODE_RUN) begin
      presc <= wrap ? '0 : presc + PRE_W'(1);
    end
  end

  assign sec_tick = wrap;

  // Carries only propagate while running; edits touch one field only.
  assign sec_inc  = wrap;
  assign min_inc  = ((state == MODE_RUN) && sec_carry) ||
                    ((state == MODE_SET_MIN) && inc_act);
  assign hour_inc = ((state == MODE_RUN) && min_carry) ||
                    ((state == MODE_SET_HOUR) && inc_act);

  bcd_mod_counter #(.MOD(SEC_MAX + 1), .TENS_W(3)) u_sec (
    .regular_clk (regular_clk),
    .reset_n     (reset_n),
    .inc_en      (sec_inc),
    .clear       (exit_to_run),
    .tens        (sec_tens),
    .ones        (sec_ones),
    .carry_out   (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MAX + 1), .TENS_W(3)) u_min (
    .regular_clk (regular_clk),
    .reset_n     (reset_n),
    .inc_en      (min_inc),
    .clear       (1'b0),
    .tens        (min_tens),
    .ones        (min_ones),
    .carry_out   (min_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MAX + 1), .TENS_W(2)) u_hour (
    .regular_clk (regular_clk),
    .reset_n     (reset_n),
    .inc_en      (hour_inc),
    .clear       (1'b0),
    .tens        (hour_tens),
    .ones        (hour_ones),
    .carry_out   ()
  );

  // Blink restarts visible on every edit so the user sees the new value.
  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (state_next == MODE_RUN) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (set_entry || inc_act) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLK_MAX) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller with TICKS_PER_SEC=4, BLINK_DIV=2.
module tb_time_set_controller;

  logic       regular_clk = 1'b0;
  logic       reset_n;
  logic       mode_pulse, inc_pulse;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       blink, sec_tick;

  localparam logic [1:0] RUN = 2'b00, SH = 2'b01, SM = 2'b10;

  time_set_controller #(.TICKS_PER_SEC(4), .BLINK_DIV(2)) dut (
    .regular_clk (regular_clk),
    .reset_n     (reset_n),
    .mode_pulse  (mode_pulse),
    .inc_pulse   (inc_pulse),
    .hour_tens   (hour_tens),
    .hour_ones   (hour_ones),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .mode        (mode),
    .blink       (blink),
    .sec_tick    (sec_tick)
  );

  always #5 regular_clk = ~regular_clk;

  int cyc = 0;
  always @(posedge regular_clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         due;
    logic [19:0] tod;
    logic [1:0] md;
    logic       cb, bl, ct, tk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [19:0] bcd_tod(input int h, input int m, input int s);
    logic [1:0] ht; logic [3:0] ho; logic [2:0] mt; logic [3:0] mo;
    logic [2:0] st; logic [3:0] so;
    ht = 2'(h / 10); ho = 4'(h % 10);
    mt = 3'(m / 10); mo = 4'(m % 10);
    st = 3'(s / 10); so = 4'(s % 10);
    return {ht, ho, mt, mo, st, so};
  endfunction

  // Monitor: compares every scoreboard entry on the falling edge of its due cycle.
  always @(negedge regular_clk) begin
    logic [19:0] got;
    exp_t e;
    got = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due < cyc) begin
        $display("FAIL %s: not sampled in cycle %0d (now %0d)", e.name, e.due, cyc);
      end else if (got == e.tod && mode == e.md &&
                   (!e.cb || blink == e.bl) && (!e.ct || sec_tick == e.tk)) begin
        passed++;
      end else begin
        $display("FAIL %s: got time=%h mode=%0d blink=%b tick=%b, want time=%h mode=%0d blink=%b(chk %b) tick=%b(chk %b)",
                 e.name, got, mode, blink, sec_tick, e.tod, e.md, e.bl, e.cb, e.tk, e.ct);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge regular_clk);
    #1;
  endtask

  task automatic expect_t(input string nm, input int h, input int m, input int s,
                          input logic [1:0] md, input logic cb, input logic bl,
                          input logic ct, input logic tk);
    exp_t e;
    e.name = nm; e.due = cyc; e.tod = bcd_tod(h, m, s); e.md = md;
    e.cb = cb; e.bl = bl; e.ct = ct; e.tk = tk;
    sb.push_back(e);
  endtask

  task automatic press(input logic m, input logic i);
    mode_pulse = m; inc_pulse = i;
    step(1);
    mode_pulse = 1'b0; inc_pulse = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
    step(2);
    expect_t("reset_state", 0, 0, 0, RUN, 1, 1, 1, 0);
    step(1);
    reset_n = 1'b1;

    // Free run: tick on every 4th cycle, seconds follow.
    for (int k = 1; k <= 12; k++) begin
      step(1);
      expect_t($sformatf("run_k%0d", k), 0, 0, k / 4, RUN, 1, 1, 1, (k % 4) == 3);
    end
    step(2);
    reset_n = 1'b0;
    expect_t("async_reset", 0, 0, 0, RUN, 1, 1, 1, 0);
    step(1);
    reset_n = 1'b1;

    // Set 23:59 and leave edit mode.
    press(1, 0);
    expect_t("enter_set_hour", 0, 0, 0, SH, 1, 1, 1, 0);
    repeat (23) press(0, 1);
    expect_t("hour_23", 23, 0, 0, SH, 1, 1, 1, 0);
    press(1, 0);
    expect_t("enter_set_min", 23, 0, 0, SM, 1, 1, 1, 0);
    repeat (59) press(0, 1);
    expect_t("min_59", 23, 59, 0, SM, 1, 1, 1, 0);
    mode_pulse = 1'b1;
    step(1);
    mode_pulse = 1'b0;
    expect_t("exit_run", 23, 59, 0, RUN, 1, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      expect_t($sformatf("exit_k%0d", k), 23, 59, k / 4, RUN, 1, 1, 1, k == 3);
    end
    step(232);
    expect_t("sec_59", 23, 59, 59, RUN, 1, 1, 1, 0);
    step(3);
    expect_t("pre_rollover_tick", 23, 59, 59, RUN, 1, 1, 1, 1);
    step(1);
    expect_t("day_rollover", 0, 0, 0, RUN, 1, 1, 1, 0);

    // Field wrap without carry.
    press(1, 0);
    repeat (24) press(0, 1);
    expect_t("hour_wrap24", 0, 0, 0, SH, 0, 0, 1, 0);
    press(1, 0);
    repeat (7) press(0, 1);
    expect_t("min_07", 0, 7, 0, SM, 0, 0, 1, 0);
    repeat (60) press(0, 1);
    expect_t("min_wrap60", 0, 7, 0, SM, 0, 0, 1, 0);
    press(1, 0);
    press(1, 0);
    expect_t("reenter_hour", 0, 7, 0, SH, 0, 0, 1, 0);
    repeat (5) press(0, 1);
    expect_t("hour_05", 5, 7, 0, SH, 0, 0, 1, 0);

    // Simultaneous events: mode wins.
    press(1, 1);
    expect_t("mode_wins", 5, 7, 0, SM, 0, 0, 1, 0);

    // Held INC: one event, blink restarts then toggles every 2 cycles.
    inc_pulse = 1'b1;
    step(1);
    expect_t("hold_j0", 5, 8, 0, SM, 1, 1, 1, 0);
    for (int j = 1; j <= 9; j++) begin
      step(1);
      expect_t($sformatf("hold_j%0d", j), 5, 8, 0, SM, 1, ((j / 2) % 2) == 0, 1, 0);
    end
    inc_pulse = 1'b0;
    step(1);

    // Exit at a non-zero frozen prescaler phase, then INC ignored in RUN.
    mode_pulse = 1'b1;
    step(1);
    mode_pulse = 1'b0;
    expect_t("exit2_run", 5, 8, 0, RUN, 1, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      expect_t($sformatf("exit2_k%0d", k), 5, 8, k / 4, RUN, 1, 1, 1, k == 3);
    end
    press(0, 1);
    press(0, 1);
    expect_t("inc_ignored_run", 5, 8, 2, RUN, 1, 1, 1, 0);

    step(2);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
